// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  localparam logic [PC_W-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO of {pc, instr} entries with synchronous flush.
module fetch_queue
  import mips_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  fetch_entry_t       wdata_i,
  output fetch_entry_t       rdata_o,
  output logic [CNT_W-1:0]   count_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam fetch_entry_t ENTRY_RST = '{pc: '0, instr: NOP};

  fetch_entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Pointer/count update; flush wins over push and pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
      else if (!push_ok && pop_ok) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: ENTRY_RST};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, single-outstanding imem requests and
// a prefetch queue presented to the decode stage.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  output logic               imem_req_o,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  input  logic               stall_i,
  output logic               if_valid_o,
  output logic [PC_W-1:0]    if_pc_o,
  output logic [PC_W-1:0]    if_pc4_o,
  output logic [INSTR_W-1:0] if_instr_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  issue_pc_q, issue_pc_d;
  logic             issue, push, pop, flush;
  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty;
  fetch_entry_t     head, wentry;

  assign wentry = '{pc: issue_pc_q, instr: imem_rdata_i};

  // Next-state, issue and queue control; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    issue_pc_d = issue_pc_q;
    issue      = 1'b0;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_i) begin
      flush      = 1'b1;
      fetch_pc_d = {redirect_pc_i[PC_W-1:2], 2'b00};
      // A response landing in the redirect cycle is the stale one: discard it now.
      if (state_q != IDLE) state_d = imem_rvalid_i ? IDLE : DROP;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (q_count < CNT_W'(DEPTH)) begin
            issue      = 1'b1;
            issue_pc_d = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_W'(4);
            state_d    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid_i) begin
            push    = !q_full;
            state_d = IDLE;
          end
        end
        DROP: begin
          if (imem_rvalid_i) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      issue_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
    end
  end

  // The request pulse is quiet while reset is held.
  assign imem_req_o  = issue && rst_ni;
  assign imem_addr_o = fetch_pc_q;

  assign if_valid_o = !q_empty && !redirect_i;
  assign pop        = if_valid_o && !stall_i;
  assign if_pc_o    = head.pc;
  assign if_pc4_o   = head.pc + PC_W'(4);
  assign if_instr_o = head.instr;

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i (wentry),
    .rdata_o (head),
    .count_o (q_count),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: latency-programmable memory model,
// pop scoreboard and per-cycle checks of the request/present interface.
module tb_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        stall_i = 1'b1;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_pc4_o;
  logic [31:0] if_instr_o;

  int          total = 0;
  int          bad = 0;
  int          lat = 1;
  int          cnt = 0;
  logic [31:0] paddr = 32'h0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata = 32'h0;
  logic        inj_rvalid = 1'b0;
  logic [31:0] inj_rdata = 32'h0;
  logic [63:0] exp_q[$];

  assign imem_rvalid_i = m_rvalid | inj_rvalid;
  assign imem_rdata_i  = inj_rvalid ? inj_rdata : m_rdata;

  fetch_unit dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .stall_i       (stall_i),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_pc4_o      (if_pc4_o),
    .if_instr_o    (if_instr_o)
  );

  initial forever #5 clk_i = ~clk_i;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_q.push_back({pc, instr_of(pc)});
  endtask

  // Memory: answers each request 'lat' cycles later with instr_of(addr).
  initial begin : mem_model
    logic        rq;
    logic [31:0] ra;
    forever begin
      @(negedge clk_i);
      rq = imem_req_o;
      ra = imem_addr_o;
      @(posedge clk_i);
      #1;
      m_rvalid = 1'b0;
      if (!rst_ni) begin
        cnt = 0;
      end else begin
        if (rq) begin
          cnt   = lat;
          paddr = ra;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            m_rvalid = 1'b1;
            m_rdata  = instr_of(paddr);
          end
        end
      end
    end
  end

  // Scoreboard: every consumed head must match the next expected entry.
  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk_i);
      if (rst_ni && if_valid_o && !stall_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL pop_unexpected: got pc=%h instr=%h, required no pop", if_pc_o, if_instr_o);
        end else begin
          e = exp_q.pop_front();
          chk("pop_pc", if_pc_o, e[63:32]);
          chk("pop_pc4", if_pc4_o, e[63:32] + 32'd4);
          chk("pop_instr", if_instr_o, e[31:0]);
        end
      end
    end
  end

  // Apply reset for two cycles, check reset values, release at cycle 0.
  task automatic do_reset(input int latency);
    chk("leftover_expected", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    stall_i    = 1'b1;
    redirect_i = 1'b0;
    inj_rvalid = 1'b0;
    rst_ni     = 1'b0;
    @(negedge clk_i);
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    next_cycle();
    lat    = latency;
    rst_ni = 1'b1;
  endtask

  typedef struct {
    logic        stall;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  vec_t        vt[8];
  int          nreq;
  logic [31:0] reqa[2];

  initial begin : main
    vt[0] = '{1'b0, 1'b1, 32'h0, 1'b0, 32'h0};
    vt[1] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[2] = '{1'b0, 1'b1, 32'h4, 1'b1, 32'h0};
    vt[3] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[4] = '{1'b0, 1'b1, 32'h8, 1'b1, 32'h4};
    vt[5] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};
    vt[6] = '{1'b0, 1'b1, 32'hC, 1'b1, 32'h8};
    vt[7] = '{1'b0, 1'b0, 32'h0, 1'b0, 32'h0};

    next_cycle();

    // Free-running fetch, latency 1.
    do_reset(1);
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
    for (int i = 0; i < 8; i++) begin
      stall_i = vt[i].stall;
      @(negedge clk_i);
      chk("t1_req", 32'(imem_req_o), 32'(vt[i].req));
      if (vt[i].req) chk("t1_addr", imem_addr_o, vt[i].addr);
      chk("t1_valid", 32'(if_valid_o), 32'(vt[i].valid));
      if (vt[i].valid) begin
        chk("t1_pc", if_pc_o, vt[i].pc);
        chk("t1_pc4", if_pc4_o, vt[i].pc + 32'd4);
      end
      next_cycle();
    end
    stall_i = 1'b1;

    // Stall with a full queue, then release.
    do_reset(1);
    push_exp(32'h0); push_exp(32'h4);
    nreq = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk_i);
      if (imem_req_o) begin
        if (nreq < 2) reqa[nreq] = imem_addr_o;
        nreq++;
      end
      if (c >= 2) begin
        chk("t2_valid_hold", 32'(if_valid_o), 32'd1);
        chk("t2_pc_hold", if_pc_o, 32'h0);
      end
      next_cycle();
    end
    chk("t2_req_count", 32'(nreq), 32'd2);
    chk("t2_req0", reqa[0], 32'h0);
    chk("t2_req1", reqa[1], 32'h4);
    stall_i = 1'b0;
    @(negedge clk_i);
    chk("t2_no_req_full", 32'(imem_req_o), 32'd0);
    next_cycle();
    @(negedge clk_i);
    chk("t2_resume_req", 32'(imem_req_o), 32'd1);
    chk("t2_resume_addr", imem_addr_o, 32'h8);
    chk("t2_second_head", if_pc_o, 32'h4);
    next_cycle();
    stall_i = 1'b1;
    @(negedge clk_i);
    chk("t2_drained", 32'(if_valid_o), 32'd0);
    next_cycle();

    // Redirect while the request for 8 is outstanding, latency 3.
    do_reset(3);
    stall_i = 1'b0;
    push_exp(32'h0); push_exp(32'h4); push_exp(32'h100);
    for (int c = 0; c < 17; c++) begin
      redirect_i    = (c == 10);
      redirect_pc_i = 32'h0000_0103;
      @(negedge clk_i);
      if (c == 8)  chk("t3_req8", imem_addr_o, 32'h8);
      if (c == 10) chk("t3_redir_req", 32'(imem_req_o), 32'd0);
      if (c == 11) chk("t3_drop_req", 32'(imem_req_o), 32'd0);
      if (c == 12) begin
        chk("t3_new_req", 32'(imem_req_o), 32'd1);
        chk("t3_new_addr", imem_addr_o, 32'h100);
      end
      if (c >= 10 && c <= 15) chk("t3_no_valid", 32'(if_valid_o), 32'd0);
      if (c == 16) chk("t3_first_valid", 32'(if_valid_o), 32'd1);
      next_cycle();
    end
    redirect_i = 1'b0;
    stall_i    = 1'b1;

    // Redirect in a cycle where push and pop would coincide.
    do_reset(1);
    push_exp(32'h300);
    for (int c = 0; c < 7; c++) begin
      redirect_i    = (c == 3);
      redirect_pc_i = 32'h0000_0300;
      stall_i       = (c < 3);
      @(negedge clk_i);
      if (c == 2) begin
        chk("t4_head", if_pc_o, 32'h0);
        chk("t4_valid_pre", 32'(if_valid_o), 32'd1);
      end
      if (c == 3) begin
        chk("t4_valid_redir", 32'(if_valid_o), 32'd0);
        chk("t4_req_redir", 32'(imem_req_o), 32'd0);
      end
      if (c == 4) begin
        chk("t4_flushed", 32'(if_valid_o), 32'd0);
        chk("t4_req_target", imem_addr_o, 32'h300);
        chk("t4_req_pulse", 32'(imem_req_o), 32'd1);
      end
      if (c == 5) chk("t4_empty", 32'(if_valid_o), 32'd0);
      if (c == 6) chk("t4_target_valid", 32'(if_valid_o), 32'd1);
      next_cycle();
    end
    redirect_i = 1'b0;
    stall_i    = 1'b1;

    // Redirect to the top of the address space: PC wraps to 0.
    do_reset(1);
    push_exp(32'hFFFF_FFFC); push_exp(32'h0);
    for (int c = 0; c < 7; c++) begin
      redirect_i    = (c == 0);
      redirect_pc_i = 32'hFFFF_FFFC;
      stall_i       = (c < 5);
      @(negedge clk_i);
      if (c == 0) chk("t5_redir_req", 32'(imem_req_o), 32'd0);
      if (c == 1) chk("t5_addr_top", imem_addr_o, 32'hFFFF_FFFC);
      if (c == 3) begin
        chk("t5_addr_wrap", imem_addr_o, 32'h0);
        chk("t5_req_wrap", 32'(imem_req_o), 32'd1);
        chk("t5_head_pc", if_pc_o, 32'hFFFF_FFFC);
        chk("t5_head_pc4", if_pc4_o, 32'h0);
      end
      if (c == 4) chk("t5_hold_instr", if_instr_o, instr_of(32'hFFFF_FFFC));
      next_cycle();
    end
    stall_i = 1'b1;

    // Reset while a request is in flight; a stray response follows release.
    do_reset(3);
    @(negedge clk_i);
    chk("t6_req_pre", 32'(imem_req_o), 32'd1);
    next_cycle();
    rst_ni = 1'b0;
    @(negedge clk_i);
    chk("t6_rst_req", 32'(imem_req_o), 32'd0);
    chk("t6_rst_addr", imem_addr_o, 32'h0);
    chk("t6_rst_valid", 32'(if_valid_o), 32'd0);
    next_cycle();
    next_cycle();
    lat    = 1;
    rst_ni = 1'b1;
    push_exp(32'h0); push_exp(32'h4);
    for (int c = 0; c < 6; c++) begin
      inj_rvalid = (c == 2);
      inj_rdata  = 32'hDEAD_BEEF;
      stall_i    = (c < 4);
      @(negedge clk_i);
      if (c == 0) begin
        chk("t6_first_req", 32'(imem_req_o), 32'd1);
        chk("t6_first_addr", imem_addr_o, 32'h0);
      end
      if (c == 3) chk("t6_head_instr", if_instr_o, instr_of(32'h0));
      if (c == 5) chk("t6_second_pc", if_pc_o, 32'h4);
      next_cycle();
    end
    inj_rvalid = 1'b0;
    stall_i    = 1'b1;
    next_cycle();

    chk("final_leftover", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1);
  end

endmodule
